// File: rtl/act_pack_vp.sv
// Packs 2/4/8-bit quantized activations LSB-first into OUT_WIDTH-bit words with flush support.
// One cycle from last field to vld_o; one held word absorbs a stalled output before rdy_o drops.
module act_pack_vp #(
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           data_i,
    input  logic                 vld_i,
    output logic                 rdy_o,
    input  logic [1:0]           fmap_precision,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] pack_o,
    output logic [7:0]           fields_o,
    output logic                 vld_o,
    input  logic                 rdy_i
);

    localparam logic [7:0] LANES2 = 8'(OUT_WIDTH / 2);
    localparam logic [7:0] LANES4 = 8'(OUT_WIDTH / 4);
    localparam logic [7:0] LANES8 = 8'(OUT_WIDTH / 8);

    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] acc_nxt;
    logic [OUT_WIDTH-1:0] field;
    logic [7:0]           lane_cnt;
    logic [7:0]           cnt_nxt;
    logic [7:0]           lanes;
    logic [7:0]           shamt;
    logic [7:0]           mask;
    logic [1:0]           prec_q;
    logic [1:0]           prec;
    logic                 acc_full;
    logic                 accept;
    logic                 flush_acc;
    logic                 slot_free;
    logic                 complete;

    assign rdy_o = !acc_full;

    always_comb begin
        // Precision is taken live on the first field and from the latch afterwards.
        prec = (lane_cnt == 8'd0) ? fmap_precision : prec_q;
        case (prec)
            2'd0: begin
                mask  = 8'h03;
                lanes = LANES2;
                shamt = lane_cnt << 1;
            end
            2'd1: begin
                mask  = 8'h0F;
                lanes = LANES4;
                shamt = lane_cnt << 2;
            end
            default: begin
                mask  = 8'hFF;
                lanes = LANES8;
                shamt = lane_cnt << 3;
            end
        endcase
        accept    = vld_i && !acc_full;
        flush_acc = flush && !acc_full;
        field     = {{(OUT_WIDTH-8){1'b0}}, data_i & mask} << shamt;
        acc_nxt   = accept ? (acc | field) : acc;
        cnt_nxt   = lane_cnt + {7'd0, accept};
        complete  = (accept && cnt_nxt == lanes) || (flush_acc && cnt_nxt != 8'd0);
        slot_free = !vld_o || rdy_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc      <= '0;
            lane_cnt <= 8'd0;
            prec_q   <= 2'd0;
            acc_full <= 1'b0;
            pack_o   <= '0;
            fields_o <= 8'd0;
            vld_o    <= 1'b0;
        end else if (acc_full) begin
            // A held word keeps its lane count until it moves to the output register.
            if (slot_free) begin
                pack_o   <= acc;
                fields_o <= lane_cnt;
                vld_o    <= 1'b1;
                acc      <= '0;
                lane_cnt <= 8'd0;
                acc_full <= 1'b0;
            end
        end else begin
            if (accept && lane_cnt == 8'd0) begin
                prec_q <= fmap_precision;
            end
            if (complete && slot_free) begin
                pack_o   <= acc_nxt;
                fields_o <= cnt_nxt;
                vld_o    <= 1'b1;
                acc      <= '0;
                lane_cnt <= 8'd0;
            end else if (complete) begin
                acc      <= acc_nxt;
                lane_cnt <= cnt_nxt;
                acc_full <= 1'b1;
            end else begin
                acc      <= acc_nxt;
                lane_cnt <= cnt_nxt;
                if (rdy_i) begin
                    vld_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_pack_vp.sv
// Directed bench for act_pack_vp: drives 1ns after posedge, samples at negedge.
module tb_act_pack_vp;

    logic        clk;
    logic        rstn;
    logic [7:0]  data_i;
    logic        vld_i;
    logic        rdy_o;
    logic [1:0]  fmap_precision;
    logic        flush;
    logic [63:0] pack_o;
    logic [7:0]  fields_o;
    logic        vld_o;
    logic        rdy_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] pk_q[$];
    logic [7:0]  fl_q[$];
    int          cy_q[$];

    act_pack_vp #(.OUT_WIDTH(64)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .data_i         (data_i),
        .vld_i          (vld_i),
        .rdy_o          (rdy_o),
        .fmap_precision (fmap_precision),
        .flush          (flush),
        .pack_o         (pack_o),
        .fields_o       (fields_o),
        .vld_o          (vld_o),
        .rdy_i          (rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a word transfers on the posedge following a negedge with vld_o && rdy_i.
    always @(negedge clk) begin
        if (rstn && vld_o && rdy_i) begin
            pk_q.push_back(pack_o);
            fl_q.push_back(fields_o);
            cy_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic fl);
        vld_i  = 1'b1;
        data_i = d;
        flush  = fl;
        step();
        vld_i  = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [63:0] pk, input logic [7:0] fl);
        check({tag, "_avail"}, 64'(pk_q.size() > 0), 64'd1);
        if (pk_q.size() > 0) begin
            check({tag, "_pack"}, pk_q.pop_front(), pk);
            check({tag, "_fields"}, 64'(fl_q.pop_front()), 64'(fl));
            void'(cy_q.pop_front());
        end
    endtask

    initial begin
        int c1;
        int c2;
        rstn = 1'b0; data_i = 8'h00; vld_i = 1'b0; flush = 1'b0;
        fmap_precision = 2'd2; rdy_i = 1'b1;
        repeat (3) step();
        check("rst_pack", pack_o, 64'd0);
        check("rst_fields", 64'(fields_o), 64'd0);
        check("rst_vld", 64'(vld_o), 64'd0);
        check("rst_rdy", 64'(rdy_o), 64'd1);
        rstn = 1'b1;
        step();

        // 8-bit word, latency of one cycle from the 8th field
        fmap_precision = 2'd2;
        for (int k = 0; k < 8; k++) begin
            send(8'(k + 1), 1'b0);
            check("b8_vld_lat", 64'(vld_o), 64'(k == 7));
        end
        step();
        check("b8_vld_clr", 64'(vld_o), 64'd0);
        expect_word("b8", 64'h0807060504030201, 8'd8);

        // 4-bit word
        fmap_precision = 2'd1;
        for (int k = 0; k < 16; k++) send(8'(k), 1'b0);
        step();
        expect_word("b4", 64'hFEDCBA9876543210, 8'd16);

        // 2-bit, two words back to back
        fmap_precision = 2'd0;
        for (int k = 0; k < 32; k++) send(8'hFF, 1'b0);
        for (int k = 0; k < 32; k++) send(8'h01, 1'b0);
        step();
        c1 = (cy_q.size() > 1) ? cy_q[0] : 0;
        c2 = (cy_q.size() > 1) ? cy_q[1] : 0;
        check("b2_gap", 64'(c2 - c1), 64'd32);
        expect_word("b2_neg1", 64'hFFFFFFFFFFFFFFFF, 8'd32);
        expect_word("b2_one", 64'h5555555555555555, 8'd32);

        // Partial word with flush coincident with the 3rd field, then a lone flush
        fmap_precision = 2'd1;
        send(8'h07, 1'b0);
        send(8'hF9, 1'b0);
        send(8'h01, 1'b1);
        check("fl_vld", 64'(vld_o), 64'd1);
        step();
        expect_word("fl", 64'h0000000000000197, 8'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check("fl_lone_none", 64'(pk_q.size()), 64'd0);
        check("fl_lone_vld", 64'(vld_o), 64'd0);

        // Backpressure: output register plus held accumulator
        fmap_precision = 2'd2;
        rdy_i = 1'b0;
        for (int k = 0; k < 16; k++) send(8'(k + 1), 1'b0);
        check("bp_rdy_low", 64'(rdy_o), 64'd0);
        check("bp_vld", 64'(vld_o), 64'd1);
        check("bp_hold", pack_o, 64'h0807060504030201);
        step();
        check("bp_stable", pack_o, 64'h0807060504030201);
        rdy_i = 1'b1;
        step();
        step();
        check("bp_rdy_back", 64'(rdy_o), 64'd1);
        check("bp_vld_clr", 64'(vld_o), 64'd0);
        expect_word("bp_w1", 64'h0807060504030201, 8'd8);
        expect_word("bp_w2", 64'h100F0E0D0C0B0A09, 8'd8);

        // Precision change mid-word is ignored; upper data bits discarded
        fmap_precision = 2'd1;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) fmap_precision = 2'd2;
            send(8'hA0 | 8'(k), 1'b0);
        end
        step();
        expect_word("prec_hold", 64'hFEDCBA9876543210, 8'd16);

        // Reset mid-word discards the partial word
        fmap_precision = 2'd2;
        for (int k = 0; k < 5; k++) send(8'h55, 1'b0);
        rstn = 1'b0;
        step();
        step();
        check("mid_rst_vld", 64'(vld_o), 64'd0);
        check("mid_rst_pack", pack_o, 64'd0);
        rstn = 1'b1;
        step();
        for (int k = 0; k < 8; k++) send(8'(8'h11 + k), 1'b0);
        step();
        check("mid_rst_count", 64'(pk_q.size()), 64'd1);
        expect_word("after_rst", 64'h1817161514131211, 8'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
